memory_game_ctrl: RTL
=====================

Name: memory_game_ctrl

Overview:
Round sequencer for the memory game. On a start press it runs a show phase: DISPLAY_CYCLE random 10-bit values are displayed on the LEDs, one per game tick, and each is written into the game register file. It then runs an entry phase: each player switch entry, on a confirm press, is compared with the stored value, and the block counts the score. It sits between the random generator and register file below and the board keys, switches and LEDs above.

Parameters:
DISPLAY_CYCLE, 10, values shown per round (1..15; sets index width 4)
SHOW_TICKS, 2, game ticks each value stays on the LEDs (>=1)

Ports:
clk  in  1  system clock, all logic on posedge
reset  in  1  synchronous, active-high reset
tick  in  1  one-clk-wide game-pace strobe
start_key  in  1  start button, level; internally rising-edge detected
confirm_key  in  1  confirm button, level; internally rising-edge detected
rand  in  10  current random value
sw  in  10  player switch entry
rdata  in  10  register file read data, combinational from rn
we  out  1  register file write enable, one clk pulse per value
wn  out  4  register file write index
d  out  10  register file write data
rn  out  4  register file read index
led  out  10  LED display
busy  out  1  high in SHOW/ENTER
score  out  4  matches counted this round
done  out  1  high in RESULT
pass  out  1  valid when done; 1 iff score==DISPLAY_CYCLE

Behaviour:
- Reset: synchronous, active-high, one clk. Next edge forces IDLE; all outputs 0; idx, tick counter and key-edge history cleared. Reset mid-round aborts with no further we pulses.
- Key edge: press = key high this clk and low the previous clk. Holding a key gives exactly one press.
- States: IDLE, LOAD, SHOW, ENTER, RESULT.
- IDLE: led=0. A start press moves to LOAD with idx=0, score=0.
- LOAD: lasts 1 clk. Samples rand. Sets led=d=rand, wn=idx, we=1 for this clk only. Goes to SHOW with tcnt=0.
- SHOW: led holds the value. Each tick increments tcnt. On the tick where tcnt reaches SHOW_TICKS:
  - if idx<DISPLAY_CYCLE-1: idx++ and go to LOAD;
  - else: led=0, idx=0, go to ENTER.
- ENTER: rn=idx; led=sw (echo). On a confirm press:
  - if sw==rdata then score++;
  - if idx==DISPLAY_CYCLE-1 then go to RESULT, else idx++.
  - Comparison uses the values present in the confirm-press clk.
- RESULT: done=1; pass registered at entry; led=all ones if pass, else 0. A start press starts a new round (to LOAD, score=0, done=0).
- Start presses in LOAD/SHOW/ENTER are ignored. Confirm presses outside ENTER are ignored. Ticks outside SHOW/LOAD are ignored. A tick in the LOAD clk is not counted.
- Simultaneous start and confirm press in RESULT: start wins; confirm is discarded.
- wn, d: hold last values between pulses; cleared on reset and on IDLE entry.
- score saturates at DISPLAY_CYCLE by construction; width 4, no wrap.
- busy = state in {LOAD, SHOW, ENTER}.

Optional Feature:
MISMATCH_ABORT_EN.
- Defined: the first mismatch in ENTER goes directly to RESULT with pass=0. score keeps matches counted so far. Remaining entries are skipped.
- Undefined: all DISPLAY_CYCLE entries are always taken. pass is decided only at the end.

Test Plan:
- Reset: DISPLAY_CYCLE=4, SHOW_TICKS=2. Assert reset for 1 clk mid-SHOW -> next edge all outputs 0, state IDLE, no further we.
- Show phase: rand sequence 0x155,0x0AA,0x3FF,0x001, tick every 5 clks, start press -> exactly 4 one-clk we pulses, wn=0..3, d=led=sequence, each value held 2 ticks, then led=0 and busy stays 1.
- Full pass: enter the same four values with confirm presses, rdata from a model register file -> score=4, done=1, pass=1, led=0x3FF.
- Partial fail: 2nd entry 0x0AB -> score=3, pass=0, led=0. With MISMATCH_ABORT_EN: RESULT right after the 2nd confirm, score=1.
- Key hygiene: hold confirm high for 20 clks in ENTER -> idx advances exactly 1. Start press during SHOW -> no restart, wn sequence unchanged.
- Restart: start press in RESULT in the same clk as a confirm press -> LOAD next clk, score=0, done=0, first we with wn=0.

Source files
------------

// File: rtl/memory_game_ctrl.sv
// memory_game_ctrl: round sequencer for the memory game.
//
// A start press begins a round. The show phase puts DISPLAY_CYCLE random values on the LEDs,
// each one for SHOW_TICKS game ticks, and writes each into the register file. The entry phase
// then compares each switch entry, taken on a confirm press, with the stored value and counts
// the score. RESULT shows the verdict until the next start press.
//
// Ports:
//   clk, reset           system clock; synchronous active-high reset
//   tick                 one-clk game-pace strobe
//   start_key            start button level (rising edge used)
//   confirm_key          confirm button level (rising edge used)
//   rand_in[9:0]         current random value ("rand" is a reserved word in SystemVerilog)
//   sw[9:0]              player switch entry
//   rdata[9:0]           register file read data, combinational from rn
//   we, wn[3:0], d[9:0]  register file write port
//   rn[3:0]              register file read index
//   led[9:0]             LED display
//   busy                 round in progress (LOAD/SHOW/ENTER)
//   score[3:0]           matches counted this round
//   done, pass           in RESULT; pass set iff every entry matched
//
// Build option: define MISMATCH_ABORT_EN to end the round at the first mismatched entry.
module memory_game_ctrl #(
    parameter int unsigned DISPLAY_CYCLE = 10,
    parameter int unsigned SHOW_TICKS    = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic       start_key,
    input  logic       confirm_key,
    input  logic [9:0] rand_in,
    input  logic [9:0] sw,
    input  logic [9:0] rdata,
    output logic       we,
    output logic [3:0] wn,
    output logic [9:0] d,
    output logic [3:0] rn,
    output logic [9:0] led,
    output logic       busy,
    output logic [3:0] score,
    output logic       done,
    output logic       pass
);

    localparam int unsigned TcntW = (SHOW_TICKS > 1) ? $clog2(SHOW_TICKS) : 1;
    localparam logic [3:0]       LastIdx   = 4'(DISPLAY_CYCLE - 1);
    localparam logic [3:0]       FullScore = 4'(DISPLAY_CYCLE);
    localparam logic [TcntW-1:0] LastTick  = TcntW'(SHOW_TICKS - 1);

    typedef enum logic [2:0] {StIdle, StLoad, StShow, StEnter, StResult} state_e;

    state_e           state_q, state_d;
    logic [3:0]       idx_q, idx_d;
    logic [TcntW-1:0] tcnt_q, tcnt_d;
    logic [3:0]       score_q, score_d;
    logic             pass_q, pass_d;
    logic [3:0]       wn_q, wn_d;
    logic [9:0]       d_q, d_d;
    logic             start_prev_q, confirm_prev_q;

    logic start_press, confirm_press;
    logic match, abort;

    assign start_press   = start_key & ~start_prev_q;
    assign confirm_press = confirm_key & ~confirm_prev_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= StIdle;
            idx_q          <= '0;
            tcnt_q         <= '0;
            score_q        <= '0;
            pass_q         <= 1'b0;
            wn_q           <= '0;
            d_q            <= '0;
            start_prev_q   <= 1'b0;
            confirm_prev_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            idx_q          <= idx_d;
            tcnt_q         <= tcnt_d;
            score_q        <= score_d;
            pass_q         <= pass_d;
            wn_q           <= wn_d;
            d_q            <= d_d;
            start_prev_q   <= start_key;
            confirm_prev_q <= confirm_key;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        tcnt_d  = tcnt_q;
        score_d = score_q;
        pass_d  = pass_q;
        wn_d    = wn_q;
        d_d     = d_q;
        match   = (sw == rdata);
`ifdef MISMATCH_ABORT_EN
        abort   = ~match;
`else
        abort   = 1'b0;
`endif

        unique case (state_q)
            StIdle: begin
                if (start_press) begin
                    state_d = StLoad;
                    idx_d   = '0;
                    score_d = '0;
                    pass_d  = 1'b0;
                end
            end
            StLoad: begin
                // The written value doubles as the SHOW display value.
                wn_d    = idx_q;
                d_d     = rand_in;
                tcnt_d  = '0;
                state_d = StShow;
            end
            StShow: begin
                if (tick) begin
                    if (tcnt_q == LastTick) begin
                        if (idx_q < LastIdx) begin
                            idx_d   = idx_q + 4'd1;
                            state_d = StLoad;
                        end else begin
                            idx_d   = '0;
                            state_d = StEnter;
                        end
                    end else begin
                        tcnt_d = tcnt_q + 1'b1;
                    end
                end
            end
            StEnter: begin
                if (confirm_press) begin
                    if (match) begin
                        score_d = score_q + 4'd1;
                    end
                    if (abort) begin
                        pass_d  = 1'b0;
                        state_d = StResult;
                    end else if (idx_q == LastIdx) begin
                        pass_d  = (score_d == FullScore);
                        state_d = StResult;
                    end else begin
                        idx_d = idx_q + 4'd1;
                    end
                end
            end
            StResult: begin
                // A confirm press in the same clk is simply not looked at here.
                if (start_press) begin
                    state_d = StLoad;
                    idx_d   = '0;
                    score_d = '0;
                    pass_d  = 1'b0;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        we    = (state_q == StLoad);
        wn    = we ? idx_q : wn_q;
        d     = we ? rand_in : d_q;
        rn    = (state_q == StEnter) ? idx_q : 4'd0;
        busy  = (state_q == StLoad) || (state_q == StShow) || (state_q == StEnter);
        done  = (state_q == StResult);
        pass  = done & pass_q;
        score = score_q;
        unique case (state_q)
            StLoad:   led = rand_in;
            StShow:   led = d_q;
            StEnter:  led = sw;
            StResult: led = pass_q ? 10'h3FF : 10'h000;
            default:  led = 10'h000;
        endcase
    end

endmodule
